// File: rtl/raggedstone_spinn_aer_if_cmd_ctrl.sv
// Command/config controller for the SpiNNaker <-> AER interface: decodes command
// packets into config registers, answers reads, and arbitrates the outbound link.
module raggedstone_spinn_aer_if_cmd_ctrl #(
   parameter int                     PKT_BITS   = 72,
   parameter logic [23:0]            CMD_PREFIX = 24'hFFFE00,
   parameter logic [31:0]            REPLY_KEY  = 32'hFFFD0000,
   parameter int                     MODE_BITS  = 3,
   parameter int                     VKEY_BITS  = 16,
   parameter logic                   INIT_GO    = 1'b0,
   parameter logic [MODE_BITS-1:0]   INIT_MODE  = '0,
   parameter logic [VKEY_BITS-1:0]   INIT_VKEY  = 16'h0200
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [PKT_BITS-1:0]   i_cpkt_data,
   input  logic                  i_cpkt_vld,
   output logic                  o_cpkt_rdy,
   input  logic [PKT_BITS-1:0]   i_epkt_data,
   input  logic                  i_epkt_vld,
   output logic                  o_epkt_rdy,
   output logic [PKT_BITS-1:0]   o_opkt_data,
   output logic                  o_opkt_vld,
   input  logic                  i_opkt_rdy,
   output logic                  o_go,
   output logic [MODE_BITS-1:0]  o_vmode,
   output logic [VKEY_BITS-1:0]  o_vkey
);
   // state   | meaning
   // IDLE    | accepting a command packet
   // DECODE  | match prefix, dispatch write/read, count drops
   // RESP    | reply being built, then offered until it wins the link
   typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_RESP} state_t;

   state_t                 r_state;
   logic [31:0]            r_key;
   logic [31:0]            r_pay;
   logic                   r_wr_pend;
   logic [3:0]             r_wr_addr;
   logic [31:0]            r_wr_data;
   logic                   r_rd_build;
   logic [3:0]             r_rd_addr;
   logic                   r_reply_vld;
   logic [PKT_BITS-1:0]    r_reply_data;
   logic [31:0]            r_evt_cnt;
   logic [15:0]            r_drop_cnt;
   logic                   r_last_rpl;
   logic                   r_locked;
   logic                   r_grant_rpl;
   logic                   r_go;
   logic [MODE_BITS-1:0]   r_vmode;
   logic [VKEY_BITS-1:0]   r_vkey;

   logic                   w_cmd_match;
   logic [3:0]             w_op;
   logic [31:0]            w_rd_val;
   logic [31:0]            w_rpl_key;
   logic                   w_gnt_rpl;
   logic                   w_xfer;
   logic                   w_evt_hs;
   logic                   w_rpl_hs;
   logic                   w_unused;

   assign w_cmd_match = (r_key[31:8] == CMD_PREFIX);
   assign w_op        = r_key[7:4];
   assign w_rpl_key   = REPLY_KEY | {28'b0, r_rd_addr};
   assign w_unused    = ^{i_cpkt_data[7:0], r_wr_data};

   always_comb begin
      w_rd_val = '0;
      case (r_rd_addr)
         4'd0:    w_rd_val = {31'b0, r_go};
         4'd1:    w_rd_val = {{(32-MODE_BITS){1'b0}}, r_vmode};
         4'd2:    w_rd_val = {{(32-VKEY_BITS){1'b0}}, r_vkey};
         4'd3:    w_rd_val = r_evt_cnt;
         4'd4:    w_rd_val = {16'b0, r_drop_cnt};
         default: w_rd_val = '0;
      endcase
   end

   // Once a packet is offered and stalled, the grant is frozen so the data cannot change.
   always_comb begin
      if (r_locked)
         w_gnt_rpl = r_grant_rpl;
      else if (r_reply_vld && i_epkt_vld)
         w_gnt_rpl = ~r_last_rpl;
      else
         w_gnt_rpl = r_reply_vld;
   end

   assign o_opkt_vld  = r_reply_vld | i_epkt_vld;
   assign o_opkt_data = w_gnt_rpl ? r_reply_data : i_epkt_data;
   assign o_epkt_rdy  = i_opkt_rdy & ~w_gnt_rpl;
   assign o_cpkt_rdy  = (r_state == ST_IDLE);
   assign w_xfer      = o_opkt_vld & i_opkt_rdy;
   assign w_evt_hs    = w_xfer & ~w_gnt_rpl;
   assign w_rpl_hs    = w_xfer & w_gnt_rpl;

   assign o_go    = r_go;
   assign o_vmode = r_vmode;
   assign o_vkey  = r_vkey;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_key        <= '0;
         r_pay        <= '0;
         r_wr_pend    <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_rd_build   <= 1'b0;
         r_rd_addr    <= '0;
         r_reply_vld  <= 1'b0;
         r_reply_data <= '0;
         r_evt_cnt    <= '0;
         r_drop_cnt   <= '0;
         r_last_rpl   <= 1'b0;
         r_locked     <= 1'b0;
         r_grant_rpl  <= 1'b0;
         r_go         <= INIT_GO;
         r_vmode      <= INIT_MODE;
         r_vkey       <= INIT_VKEY;
      end else begin
         r_wr_pend  <= 1'b0;
         r_rd_build <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_cpkt_vld) begin
                  r_key   <= i_cpkt_data[39:8];
                  r_pay   <= i_cpkt_data[71:40];
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (w_cmd_match && w_op == 4'd0) begin
                  r_wr_pend <= 1'b1;
                  r_wr_addr <= r_key[3:0];
                  r_wr_data <= r_pay;
                  r_state   <= ST_IDLE;
               end else if (w_cmd_match && w_op == 4'd1) begin
                  r_rd_build <= 1'b1;
                  r_rd_addr  <= r_key[3:0];
                  r_state    <= ST_RESP;
               end else begin
                  if (r_drop_cnt != 16'hFFFF)
                     r_drop_cnt <= r_drop_cnt + 16'd1;
                  r_state <= ST_IDLE;
               end
            end
            ST_RESP: begin
               if (w_rpl_hs) begin
                  r_reply_vld <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Header bit0 makes the whole 72-bit reply odd parity (header bit1 is already 1).
         if (r_rd_build) begin
            r_reply_vld  <= 1'b1;
            r_reply_data <= {w_rd_val, w_rpl_key, 6'b0, 1'b1, ^{w_rd_val, w_rpl_key}};
         end

         if (w_evt_hs)
            r_evt_cnt <= r_evt_cnt + 32'd1;

         if (r_wr_pend) begin
            case (r_wr_addr)
               4'd0:    r_go       <= r_wr_data[0];
               4'd1:    r_vmode    <= r_wr_data[MODE_BITS-1:0];
               4'd2:    r_vkey     <= r_wr_data[VKEY_BITS-1:0];
               4'd3:    r_evt_cnt  <= '0;
               4'd4:    r_drop_cnt <= '0;
               default: ;
            endcase
         end

         r_locked    <= o_opkt_vld & ~i_opkt_rdy;
         r_grant_rpl <= w_gnt_rpl;
         if (w_xfer)
            r_last_rpl <= w_gnt_rpl;
      end
   end
endmodule

// File: doc/raggedstone_spinn_aer_if_cmd_ctrl.md
Name: raggedstone_spinn_aer_if_cmd_ctrl

Overview:
Command/configuration controller for the SpiNNaker <-> AER interface. It decodes multicast command packets arriving from SpiNNaker and writes the interface configuration registers (go, mode, virtual key). It answers register reads with reply packets. It shares the outbound SpiNNaker link between AER event packets and those reply packets, using a fair, stall-safe arbiter.

Parameters:
PKT_BITS, 72, SpiNNaker packet width: [7:0] header, [39:8] key, [71:40] payload
CMD_PREFIX, 24'hFFFE00, command keys match when key[31:8] == CMD_PREFIX
REPLY_KEY, 32'hFFFD0000, reply packet key is REPLY_KEY | {28'b0, addr}
MODE_BITS, 3, width of vmode
VKEY_BITS, 16, width of vkey
INIT_GO, 1'b0, reset value of go
INIT_MODE, 3'd0, reset value of vmode
INIT_VKEY, 16'h0200, reset value of vkey

Ports:
clk  in  1  system clock
rst  in  1  reset
cpkt_data  in  PKT_BITS  command packet from SpiNNaker
cpkt_vld  in  1  command packet valid
cpkt_rdy  out  1  command packet ready
epkt_data  in  PKT_BITS  AER event packet to SpiNNaker
epkt_vld  in  1  event packet valid
epkt_rdy  out  1  event packet ready
opkt_data  out  PKT_BITS  packet to SpiNNaker link transmitter
opkt_vld  out  1  outbound valid
opkt_rdy  in  1  outbound ready
go  out  1  interface enable
vmode  out  MODE_BITS  retina/sensor mode
vkey  out  VKEY_BITS  virtual key for generated events

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Handshake: a transfer occurs when vld&rdy are high at a rising clk edge. The sender holds data stable while vld is high and rdy is low.
- Reset values: go=INIT_GO, vmode=INIT_MODE, vkey=INIT_VKEY. FSM=IDLE, opkt_vld=0, evt_cnt=0, drop_cnt=0, last_grant=EVT. cpkt_rdy=1 during reset release.
- Reset asserted mid-operation abandons any pending reply immediately. opkt_vld=0 in the next cycle.
- FSM states:
  - IDLE: cpkt_rdy=1. On cpkt handshake, latch key/payload and go to DECODE.
  - DECODE: cpkt_rdy=0. A command matches when key[31:8]==CMD_PREFIX; then op=key[7:4] and addr=key[3:0].
    - Non-matching packet: drop_cnt+1, saturating at 16'hFFFF; go to IDLE.
    - op=0 (write): perform the write, go to IDLE.
    - op=1 (read): build the reply, go to RESP.
    - Any other op: count as a drop.
  - RESP: the reply is pending. Leave for IDLE on the cycle the reply wins arbitration and opkt_rdy=1.
- Register map (addr):
  - 0 GO: bit0. Write sets go.
  - 1 MODE: [MODE_BITS-1:0].
  - 2 VKEY: [VKEY_BITS-1:0].
  - 3 EVT_CNT: 32-bit, read-only. Increments on every event handshake on opkt and wraps at 2^32. Any write clears it; if an increment occurs in the same cycle, the clear wins (result 0).
  - 4 DROP_CNT: 16-bit, zero-extended on read. Any write clears it.
  - Reads of undefined addresses return 0. Writes to undefined addresses are ignored and are not counted as drops.
- Write latency: command handshake at edge T; the register output changes at edge T+2.
- Read latency: command handshake at edge T; opkt_vld with the reply is offered from edge T+2.
- Reply format:
  - header = 8'b0000_001p, with bit1 = payload present.
  - p is chosen so the XOR of all 72 bits is 1 (odd parity).
  - key = REPLY_KEY|addr; payload = register value.
- Arbiter:
  - opkt_vld = reply_pending | epkt_vld.
  - When only one source requests, it is granted.
  - When both request, the source not granted last (last_grant) wins.
  - last_grant updates only on an opkt handshake.
  - Grant is locked while opkt_vld=1 and opkt_rdy=0. A newly arriving requester never switches the offered packet.
  - epkt_rdy = opkt_rdy & (grant==EVT). opkt_data is a combinational mux of the granted source.
- evt_cnt counts event handshakes only; replies are not counted.
- go, vmode and vkey are registered outputs and never glitch.

Test Plan:
- Reset, then idle -> go=0, vmode=0, vkey=16'h0200, opkt_vld=0, cpkt_rdy=1.
- Write cmd: key 32'hFFFE0002, payload 32'h00001234 -> vkey=16'h1234 two edges after the handshake; cpkt_rdy=0 for exactly one cycle.
- Read cmd: key 32'hFFFE0011 with opkt_rdy=1 -> opkt_data has header 8'h02 or 8'h03 (odd total parity), key 32'hFFFD0001, payload = vmode. The reply appears at T+2.
- Non-matching key 32'h12345678 sent 3 times, then read of addr 4 -> reply payload 32'h3; go/vmode/vkey unchanged.
- Continuous epkt_vld, a read command, and opkt_rdy held low 5 cycles -> the offered event packet stays stable with epkt_rdy=0. After release, replies and events alternate. A read of addr 3 returns the exact event handshake count.
- Write addr 3 in the same cycle an event is accepted -> EVT_CNT reads 0. Assert rst while in RESP -> opkt_vld=0 the next cycle, and all outputs return to their reset values.
